eth_cmd_ctrl: RTL and testbench
===============================

# eth_cmd_ctrl

Command/reply sequencer between the 1G RGMII MAC byte streams and the board top level. It parses raw-Ethernet command frames from the MAC receive stream and presents them as `cmd`/`address`/`value` with a ready handshake. It wraps 32-bit reply words from the top level into a framed byte stream on the MAC transmit side. Reply words come from either a register read or an SDRAM data stream.

## Interface
- `MY_MAC`, 48'h0200_0000_0001, board MAC address; source address of replies.
- `ETHERTYPE`, 16'h88B5, ethertype required on commands and sent on replies.
- `clk125` in 1: single clock, 125 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `rdata` in 8 / `rvalid` in 1 / `rlast` in 1 / `ruser` in 1: MAC receive stream.
- `rready` out 1: receive-stream ready.
- `tdata` out 8 / `tvalid` out 1 / `tlast` out 1: MAC transmit stream.
- `tready` in 1: transmit-stream ready.
- `cmd` out 3 / `address` out 32 / `value` out 32: pending command. Codes: 1 = SDRAM read, 2 = register read, 3 = register write.
- `ready4cmd` in 1: top level accepts the pending command.
- `txd` in 32 / `txvld` in 1 / `txend` in 1: reply words; `txend` marks the last word.
- `txready` out 1: word accepted when `txvld && txready`.
- `frame_ok` out 1: one-cycle pulse per accepted command frame.
- `frame_drop` out 1: one-cycle pulse per discarded frame.

## Operation
- A byte transfers when `valid && ready`. All multi-byte fields are big-endian.
- Receive frame layout: dst[0..5], src[6..11], ethertype[12..13], cmdword[14..17], address[18..21], value[22..25]. Bytes after 25 (padding) are ignored.
- Receive FSM states:
  - R_BYTE: 5-bit byte counter, saturating at 26; captures fields.
  - R_DROP: waits for `rlast`.
  - R_CMD: command pending.
- A frame is dropped (`frame_drop` pulses) when any of these holds:
  - ethertype ≠ ETHERTYPE;
  - `rlast` arrives before byte 25;
  - `ruser`=1 on the `rlast` byte;
  - cmdword[2:0] ∈ {0, 4..7}.
- A dropped frame returns the FSM to R_BYTE after `rlast`.
- A valid frame at `rlast`:
  - latches cmd/address/value and src MAC;
  - latches cmdword as the reply tag;
  - pulses `frame_ok` and enters R_CMD.
- R_CMD:
  - `rready`=0; the MAC FIFO buffers further frames.
  - `cmd` is held until the cycle `ready4cmd`=1, then `cmd` returns to 0 and the FSM enters R_BYTE.
  - At acceptance, src MAC and tag copy into reply registers. These stay stable until the next acceptance.
- `rready`=1 in R_BYTE and R_DROP.
- Transmit FSM states:
  - T_IDLE, `txready`=1: the first accepted word is stored and the FSM goes to T_HDR.
  - T_HDR emits 18 bytes: reply dst = latched src MAC, MY_MAC, ETHERTYPE, 4-byte tag.
  - T_WORD emits the 4 bytes of the stored word, MSB first.
  - After the last byte of a non-final word, the FSM goes to T_WAIT (`txready`=1). The next accepted word returns it to T_WORD.
  - After the last byte of the `txend` word, `tlast`=1 on that byte and the FSM goes to T_IDLE.
- `txready`=0 in T_HDR and T_WORD.
- `tvalid`/`tdata`/`tlast` stay stable while `tready`=0.
- The transmit and receive FSMs are independent. A new command may be issued while a reply is being sent.
- The top level sequences replies. A reply already in flight keeps the reply registers captured at its T_IDLE exit.

## Timing
- Reset values:
  - `rready`=1, `cmd`=0, `address`=0, `value`=0;
  - `tvalid`=0, `tlast`=0, `tdata`=0;
  - `txready`=1, `frame_ok`=0, `frame_drop`=0;
  - FSMs in R_BYTE / T_IDLE.
- `cmd` is valid the cycle after the accepted `rlast` byte. `frame_ok`/`frame_drop` pulse in that same cycle.
- `ready4cmd` high while `cmd`=0 has no effect.
- First `tvalid` comes 1 cycle after the first word is accepted.
- With `tready` held high, a frame of N words takes 18+4N consecutive bytes with no bubbles inside header or word. T_WAIT adds ≥1 cycle between words.
- `txend` is sampled only with an accepted word. With `txend` on the first word, the frame is 22 bytes.
- Reset mid-frame:
  - receive drops the partial capture;
  - transmit deasserts `tvalid` immediately, leaving a truncated frame for the MAC to handle.

## Configuration
- `ETH_CMD_MACFILTER_EN` defined: dst must equal MY_MAC or FF:FF:FF:FF:FF:FF. Any other dst drops the frame.
- Not defined: dst bytes are ignored.

## Test plan
- Register write: frame with ethertype 88B5, cmdword 0x00000003, addr 0x10, value 0xDEADBEEF; `ready4cmd`=1. Expect `cmd`=3, addr 0x10, value 0xDEADBEEF for 1 cycle, `frame_ok` pulse, `rready` low for exactly that cycle.
- Register read reply: cmdword 0xA5000002, then one word 0x12345678 with `txend`. Expect a 22-byte frame: dst = sender MAC, MY_MAC, 88 B5, A5 00 00 02, 12 34 56 78, `tlast` on byte 22.
- SDRAM burst under backpressure: 3 words with random `tready` gaps. Expect 30 bytes with correct order, data held during stalls, `tlast` only on byte 30.
- Drops, expect each to pulse `frame_drop` with `cmd` staying 0:
  - ethertype 0x0800;
  - frame truncated at byte 20;
  - `ruser`=1;
  - cmdword 0x00000005.
- Pending hold: second frame arrives while `ready4cmd`=0 for 100 cycles. Expect `cmd` unchanged, `rready`=0, second command presented after acceptance.
- Macro on: dst 02:00:00:00:00:99 is dropped; broadcast dst is accepted.

Source files
------------

// File: rtl/eth_cmd_ctrl.sv
// Raw-Ethernet command parser and reply framer between the RGMII MAC byte streams and the board top.
// Define ETH_CMD_MACFILTER_EN to drop command frames not addressed to MY_MAC or broadcast.
module eth_cmd_ctrl #(
  parameter logic [47:0] MY_MAC    = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk125,
  input  logic        reset,
  input  logic [7:0]  rdata,
  input  logic        rvalid,
  input  logic        rlast,
  input  logic        ruser,
  output logic        rready,
  output logic [7:0]  tdata,
  output logic        tvalid,
  output logic        tlast,
  input  logic        tready,
  output logic [2:0]  cmd,
  output logic [31:0] address,
  output logic [31:0] value,
  input  logic        ready4cmd,
  input  logic [31:0] txd,
  input  logic        txvld,
  input  logic        txend,
  output logic        txready,
  output logic        frame_ok,
  output logic        frame_drop
);

  typedef enum logic [1:0] {R_BYTE, R_DROP, R_CMD} r_state_e;
  typedef enum logic [1:0] {T_IDLE, T_HDR, T_WORD, T_WAIT} t_state_e;

  r_state_e    r_state_q, r_state_d;
  logic [4:0]  rcnt_q, rcnt_d;
  logic [47:0] src_q, src_d;
  logic [7:0]  eth_hi_q, eth_hi_d;
  logic [31:0] cw_q, cw_d, addr_q, addr_d, val_q, val_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [31:0] address_q, address_d, value_q, value_d;
  logic        frame_ok_q, frame_ok_d, frame_drop_q, frame_drop_d;
  logic [47:0] rep_mac_q, rep_mac_d;
  logic [31:0] rep_tag_q, rep_tag_d;
  logic        rx_take, eth_bad, cmd_bad, mac_bad, hdr_bad;

  assign rready  = (r_state_q != R_CMD);
  assign rx_take = rvalid && rready;
  assign eth_bad = (rcnt_q == 5'd13) && ({eth_hi_q, rdata} != ETHERTYPE);
  assign cmd_bad = (rcnt_q == 5'd17) && ((rdata[2:0] == 3'd0) || (rdata[2:0] > 3'd3));
  assign hdr_bad = eth_bad || cmd_bad || mac_bad;

`ifdef ETH_CMD_MACFILTER_EN
  logic [39:0] dst_q, dst_d;
  logic [47:0] dst_full;

  always_comb begin
    dst_d    = dst_q;
    dst_full = {dst_q, rdata};
    if (rx_take && (r_state_q == R_BYTE) && (rcnt_q <= 5'd5)) dst_d = {dst_q[31:0], rdata};
  end
  assign mac_bad = (rcnt_q == 5'd5) && (dst_full != MY_MAC) && (dst_full != 48'hFFFF_FFFF_FFFF);

  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) dst_q <= '0;
    else       dst_q <= dst_d;
  end
`else
  assign mac_bad = 1'b0;
`endif

  // Header faults are caught on the offending byte so the rest of the frame is
  // simply drained in R_DROP; length and ruser faults can only be judged at rlast.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    r_state_d    = r_state_q;
    rcnt_d       = rcnt_q;
    src_d        = src_q;
    eth_hi_d     = eth_hi_q;
    cw_d         = cw_q;
    addr_d       = addr_q;
    val_d        = val_q;
    cmd_d        = cmd_q;
    address_d    = address_q;
    value_d      = value_q;
    frame_ok_d   = 1'b0;
    frame_drop_d = 1'b0;
    rep_mac_d    = rep_mac_q;
    rep_tag_d    = rep_tag_q;
    case (r_state_q)
      R_BYTE: if (rx_take) begin
        if ((rcnt_q >= 5'd6) && (rcnt_q <= 5'd11))  src_d = {src_q[39:0], rdata};
        if (rcnt_q == 5'd12)                        eth_hi_d = rdata;
        if ((rcnt_q >= 5'd14) && (rcnt_q <= 5'd17)) cw_d = {cw_q[23:0], rdata};
        if ((rcnt_q >= 5'd18) && (rcnt_q <= 5'd21)) addr_d = {addr_q[23:0], rdata};
        if ((rcnt_q >= 5'd22) && (rcnt_q <= 5'd25)) val_d = {val_q[23:0], rdata};
        if (rlast) begin
          rcnt_d = 5'd0;
          if (hdr_bad || (rcnt_q < 5'd25) || ruser) begin
            frame_drop_d = 1'b1;
          end else begin
            cmd_d      = cw_q[2:0];
            address_d  = addr_q;
            value_d    = val_d;
            frame_ok_d = 1'b1;
            r_state_d  = R_CMD;
          end
        end else if (hdr_bad) begin
          rcnt_d    = 5'd0;
          r_state_d = R_DROP;
        end else if (rcnt_q != 5'd26) begin
          rcnt_d = rcnt_q + 5'd1;
        end
      end
      R_DROP: if (rx_take && rlast) begin
        frame_drop_d = 1'b1;
        r_state_d    = R_BYTE;
      end
      R_CMD: if (ready4cmd) begin
        cmd_d     = 3'd0;
        rep_mac_d = src_q;
        rep_tag_d = cw_q;
        r_state_d = R_BYTE;
      end
      default: r_state_d = R_BYTE;
    endcase
  end

  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      r_state_q    <= R_BYTE;
      rcnt_q       <= '0;
      src_q        <= '0;
      eth_hi_q     <= '0;
      cw_q         <= '0;
      addr_q       <= '0;
      val_q        <= '0;
      cmd_q        <= '0;
      address_q    <= '0;
      value_q      <= '0;
      frame_ok_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      rep_mac_q    <= '0;
      rep_tag_q    <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      r_state_q    <= r_state_d;
      rcnt_q       <= rcnt_d;
      src_q        <= src_d;
      eth_hi_q     <= eth_hi_d;
      cw_q         <= cw_d;
      addr_q       <= addr_d;
      val_q        <= val_d;
      cmd_q        <= cmd_d;
      address_q    <= address_d;
      value_q      <= value_d;
      frame_ok_q   <= frame_ok_d;
      frame_drop_q <= frame_drop_d;
      rep_mac_q    <= rep_mac_d;
      rep_tag_q    <= rep_tag_d;
    end
  end

  assign cmd        = cmd_q;
  assign address    = address_q;
  assign value      = value_q;
  assign frame_ok   = frame_ok_q;
  assign frame_drop = frame_drop_q;

  t_state_e     t_state_q, t_state_d;
  logic [4:0]   tcnt_q, tcnt_d;
  logic [143:0] hdr_q, hdr_d;
  logic [31:0]  word_q, word_d;
  logic         end_q, end_d;

  assign txready = (t_state_q == T_IDLE) || (t_state_q == T_WAIT);
  assign tvalid  = (t_state_q == T_HDR) || (t_state_q == T_WORD);

  // Header and word are shifted out MSB first; outputs decode straight from flops
  // so they hold while tready is low and drop at once on reset.
  always_comb begin
    tdata = 8'h00;
    tlast = 1'b0;
    if (t_state_q == T_HDR)  tdata = hdr_q[143:136];
    if (t_state_q == T_WORD) begin
      tdata = word_q[31:24];
      tlast = end_q && (tcnt_q == 5'd3);
    end
  end

  always_comb begin
    t_state_d = t_state_q;
    tcnt_d    = tcnt_q;
    hdr_d     = hdr_q;
    word_d    = word_q;
    end_d     = end_q;
    case (t_state_q)
      T_IDLE: if (txvld) begin
        hdr_d     = {rep_mac_q, MY_MAC, ETHERTYPE, rep_tag_q};
        word_d    = txd;
        end_d     = txend;
        tcnt_d    = 5'd0;
        t_state_d = T_HDR;
      end
      T_HDR: if (tready) begin
        hdr_d = {hdr_q[135:0], 8'h00};
        if (tcnt_q == 5'd17) begin
          tcnt_d    = 5'd0;
          t_state_d = T_WORD;
        end else begin
          tcnt_d = tcnt_q + 5'd1;
        end
      end
      T_WORD: if (tready) begin
        word_d = {word_q[23:0], 8'h00};
        if (tcnt_q == 5'd3) begin
          tcnt_d    = 5'd0;
          t_state_d = end_q ? T_IDLE : T_WAIT;
        end else begin
          tcnt_d = tcnt_q + 5'd1;
        end
      end
      T_WAIT: if (txvld) begin
        word_d    = txd;
        end_d     = txend;
        tcnt_d    = 5'd0;
        t_state_d = T_WORD;
      end
      default: t_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk125 or posedge reset) begin
    if (reset) begin
      t_state_q <= T_IDLE;
      tcnt_q    <= '0;
      hdr_q     <= '0;
      word_q    <= '0;
      end_q     <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      tcnt_q    <= tcnt_d;
      hdr_q     <= hdr_d;
      word_q    <= word_d;
      end_q     <= end_d;
    end
  end

endmodule

// File: tb/tb_eth_cmd_ctrl.sv
// Scoreboard bench for eth_cmd_ctrl: expected commands and reply bytes are queued
// when stimulus is driven and compared when the DUT presents them.
module tb_eth_cmd_ctrl;

  localparam logic [47:0] MY_MAC_C = 48'h0200_0000_0001;
  localparam logic [15:0] ETYPE_C  = 16'h88B5;

  logic        clk125, reset;
  logic [7:0]  rdata;
  logic        rvalid, rlast, ruser, rready;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tready;
  logic [2:0]  cmd;
  logic [31:0] address, value;
  logic        ready4cmd;
  logic [31:0] txd;
  logic        txvld, txend, txready, frame_ok, frame_drop;

  eth_cmd_ctrl dut (
    .clk125(clk125), .reset(reset),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .ruser(ruser), .rready(rready),
    .tdata(tdata), .tvalid(tvalid), .tlast(tlast), .tready(tready),
    .cmd(cmd), .address(address), .value(value), .ready4cmd(ready4cmd),
    .txd(txd), .txvld(txvld), .txend(txend), .txready(txready),
    .frame_ok(frame_ok), .frame_drop(frame_drop)
  );

  typedef struct {
    logic [2:0]  c_cmd;
    logic [31:0] c_addr;
    logic [31:0] c_val;
    logic [47:0] c_mac;
    logic [31:0] c_tag;
  } cmd_t;

  cmd_t        cmd_q[$];
  logic [8:0]  tx_q[$];
  int          checks = 0, failures = 0;
  int          exp_ok = 0, exp_drop = 0, seen_ok = 0, seen_drop = 0;
  logic [47:0] model_mac = '0;
  logic [31:0] model_tag = '0;
  bit          rand_tready = 0;
  bit          prev_cmd_nz = 0;
  bit          stall_v = 0;
  logic [7:0]  stall_d;
  logic        stall_l;

  initial begin
    clk125 = 1'b0;
    forever #4 clk125 = ~clk125;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk125);
      #1;
      tready = rand_tready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Command monitor: pending command must match the queue head and stay held.
  always @(negedge clk125) begin
    if (!reset) begin
      if (frame_ok)   seen_ok++;
      if (frame_drop) seen_drop++;
      if (cmd != 3'd0) begin
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", cmd_q.size(), 1);
        end else begin
          check("cmd", cmd, cmd_q[0].c_cmd);
          check("address", address, cmd_q[0].c_addr);
          check("value", value, cmd_q[0].c_val);
          check("rready_pending", rready, 0);
          if (!prev_cmd_nz) check("frame_ok_with_cmd", frame_ok, 1);
          if (ready4cmd) begin
            model_mac = cmd_q[0].c_mac;
            model_tag = cmd_q[0].c_tag;
            void'(cmd_q.pop_front());
          end
        end
      end
      prev_cmd_nz = (cmd != 3'd0);
    end
  end

  // Transmit monitor: transferred bytes against the queue, stalls must hold.
  always @(negedge clk125) begin
    if (!reset) begin
      if (stall_v) begin
        check("hold_tvalid", tvalid, 1);
        check("hold_tdata", tdata, stall_d);
        check("hold_tlast", tlast, stall_l);
      end
      stall_v = 0;
      if (tvalid && tready) begin
        if (tx_q.size() == 0) check("tx_extra_byte", tx_q.size(), 1);
        else begin
          check("tdata", tdata, tx_q[0][7:0]);
          check("tlast", tlast, tx_q[0][8]);
          void'(tx_q.pop_front());
        end
      end else if (tvalid) begin
        stall_v = 1;
        stall_d = tdata;
        stall_l = tlast;
      end
    end
  end

  task automatic rx_byte(input logic [7:0] b, input bit last, input bit user);
    int guard = 0;
    rdata = b; rlast = last; ruser = user; rvalid = 1'b1;
    @(negedge clk125);
    while (!rready && guard < 2000) begin
      @(negedge clk125);
      guard++;
    end
    if (!rready) check("rx_timeout", rready, 1);
    @(posedge clk125);
    #1;
    rvalid = 1'b0; rlast = 1'b0; ruser = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] eth,
                            input logic [31:0] cw, input logic [31:0] addr, input logic [31:0] val,
                            input int len, input bit user, input bit good);
    logic [207:0] f;
    cmd_t e;
    f = {dst, src, eth, cw, addr, val};
    if (good) begin
      e.c_cmd = cw[2:0]; e.c_addr = addr; e.c_val = val; e.c_mac = src; e.c_tag = cw;
      cmd_q.push_back(e);
      exp_ok++;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < len; i++) begin
      rx_byte((i < 26) ? f[207:200] : 8'h00, i == len - 1, user && (i == len - 1));
      f = f << 8;
    end
    if (good) check("frame_ok_pulse", frame_ok, 1);
    else begin
      check("frame_drop_pulse", frame_drop, 1);
      check("cmd_after_drop", cmd, 0);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit last);
    for (int j = 0; j < 4; j++) begin
      tx_q.push_back({last && (j == 3), w[31:24]});
      w = w << 8;
    end
  endtask

  task automatic send_reply(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input int n);
    logic [31:0] w;
    logic [143:0] h;
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      w = (k == 0) ? w0 : (k == 1) ? w1 : w2;
      txd = w; txend = (k == n - 1); txvld = 1'b1;
      @(negedge clk125);
      while (!txready && guard < 2000) begin
        @(negedge clk125);
        guard++;
      end
      if (!txready) check("txready_timeout", txready, 1);
      @(posedge clk125);
      #1;
      txvld = 1'b0; txend = 1'b0;
      if (k == 0) begin
        check("first_tvalid_latency", tvalid, 1);
        h = {model_mac, MY_MAC_C, ETYPE_C, model_tag};
        for (int i = 0; i < 18; i++) begin
          tx_q.push_back({1'b0, h[143:136]});
          h = h << 8;
        end
      end
      push_word(w, k == n - 1);
    end
  endtask

  task automatic wait_tx_drain();
    int guard = 0;
    while (tx_q.size() != 0 && guard < 3000) begin
      @(negedge clk125);
      guard++;
    end
    check("tx_drain", tx_q.size(), 0);
    @(posedge clk125);
    #1;
  endtask

  initial begin
    reset = 1'b1; rvalid = 1'b0; rdata = 8'h00; rlast = 1'b0; ruser = 1'b0;
    ready4cmd = 1'b0; txd = '0; txvld = 1'b0; txend = 1'b0;
    repeat (3) @(posedge clk125);
    #1;
    check("rst_rready", rready, 1);
    check("rst_cmd", cmd, 0);
    check("rst_address", address, 0);
    check("rst_value", value, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata, 0);
    check("rst_txready", txready, 1);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_drop", frame_drop, 0);
    reset = 1'b0;
    @(posedge clk125);
    #1;

    // Register write with padding, top level ready immediately.
    ready4cmd = 1'b1;
    send_frame(MY_MAC_C, 48'h0200_0000_00AA, ETYPE_C, 32'h0000_0003, 32'h10, 32'hDEADBEEF, 30, 0, 1);
    repeat (2) @(posedge clk125);
    #1;
    check("rready_back", rready, 1);

    // Register read and its single-word reply.
    send_frame(MY_MAC_C, 48'h0200_0000_00BB, ETYPE_C, 32'hA500_0002, 32'h20, 32'h0, 26, 0, 1);
    repeat (3) @(posedge clk125);
    #1;
    send_reply(32'h1234_5678, 32'h0, 32'h0, 1);
    wait_tx_drain();

    // SDRAM burst of three words under random backpressure.
    send_frame(MY_MAC_C, 48'h0200_0000_00CC, ETYPE_C, 32'h5A00_0001, 32'h1000, 32'h3, 26, 0, 1);
    repeat (3) @(posedge clk125);
    #1;
    rand_tready = 1;
    send_reply(32'hA0B0_C0D0, 32'h1122_3344, 32'hCAFE_F00D, 3);
    wait_tx_drain();
    rand_tready = 0;

    // Dropped frames.
    send_frame(MY_MAC_C, 48'h0200_0000_00DD, 16'h0800, 32'h3, 32'h1, 32'h2, 26, 0, 0);
    send_frame(MY_MAC_C, 48'h0200_0000_00DD, ETYPE_C, 32'h3, 32'h1, 32'h2, 20, 0, 0);
    send_frame(MY_MAC_C, 48'h0200_0000_00DD, ETYPE_C, 32'h3, 32'h1, 32'h2, 26, 1, 0);
    send_frame(MY_MAC_C, 48'h0200_0000_00DD, ETYPE_C, 32'h5, 32'h1, 32'h2, 26, 0, 0);

    // Pending hold: second frame waits until the first command is accepted.
    ready4cmd = 1'b0;
    send_frame(MY_MAC_C, 48'h0200_0000_00E1, ETYPE_C, 32'h0000_0002, 32'h44, 32'h0, 26, 0, 1);
    fork
      send_frame(MY_MAC_C, 48'h0200_0000_00E2, ETYPE_C, 32'h0000_0003, 32'h48, 32'h7, 26, 0, 1);
      begin
        repeat (100) @(posedge clk125);
        #1;
        ready4cmd = 1'b1;
      end
    join
    repeat (3) @(posedge clk125);
    #1;

    // Destination filtering.
`ifdef ETH_CMD_MACFILTER_EN
    send_frame(48'h0200_0000_0099, 48'h0200_0000_00F1, ETYPE_C, 32'h2, 32'h50, 32'h0, 26, 0, 0);
`else
    send_frame(48'h0200_0000_0099, 48'h0200_0000_00F1, ETYPE_C, 32'h2, 32'h50, 32'h0, 26, 0, 1);
`endif
    send_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_00F2, ETYPE_C, 32'h3, 32'h54, 32'h9, 26, 0, 1);

    repeat (10) @(posedge clk125);
    #1;
    check("cmd_queue_empty", cmd_q.size(), 0);
    check("tx_queue_empty", tx_q.size(), 0);
    check("frame_ok_count", seen_ok, exp_ok);
    check("frame_drop_count", seen_drop, exp_drop);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
